// File: rtl/multi_pwm_driver.sv
// multi_pwm_driver
//   NUM_CH PWM outputs sharing one period counter. A shared up/down button
//   pair, steered by i_chan_sel, raises or lowers the pending duty of one
//   channel. Every channel copies its pending duty into its active duty at
//   the period boundary, so a waveform never changes shape mid-period.
//
// Build option:
//   MULTI_PWM_CENTER_EN  defined   -> center-aligned counter (up/down, period 2*MAX)
//                        undefined -> edge-aligned counter (0..MAX-1, period MAX)
//
// Parameters:
//   CNTR_LEN   period counter width, MAX = 2^CNTR_LEN - 1
//   NUM_CH     number of channels (1..16)
//   STEP       duty change per press (1..MAX)
//   RESET_DUTY duty loaded into every channel on reset (0..MAX)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_cycle_up    debounced level, rising edge raises selected duty
//   i_cycle_down  debounced level, rising edge lowers selected duty
//   i_chan_sel    channel targeted by up/down events
//   PWM_pins      registered PWM outputs, one per channel
//   o_duty        pending duty of channel i_chan_sel (0 when out of range)
//   o_sync        registered one-cycle pulse at the start of each period

module multi_pwm_driver #(
  parameter int unsigned CNTR_LEN   = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RESET_DUTY = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_cycle_up,
  input  logic                                            i_cycle_down,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  i_chan_sel,
  output logic [NUM_CH-1:0]                               PWM_pins,
  output logic [CNTR_LEN-1:0]                             o_duty,
  output logic                                            o_sync
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNTR_LEN-1:0] MAX_C   = '1;
  localparam logic [CNTR_LEN-1:0] TOP_C   = MAX_C - CNTR_LEN'(1);
  localparam logic [CNTR_LEN-1:0] STEP_N  = CNTR_LEN'(STEP);
  localparam logic [CNTR_LEN:0]   STEP_W  = (CNTR_LEN + 1)'(STEP);
  localparam logic [CNTR_LEN-1:0] RESET_D = CNTR_LEN'(RESET_DUTY);

  // Input stage and edge history
  logic             up_q, up_d;
  logic             up_prev_q, up_prev_d;
  logic             dn_q, dn_d;
  logic             dn_prev_q, dn_prev_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  // Period counter
  logic [CNTR_LEN-1:0] cnt_q, cnt_d;

`ifdef MULTI_PWM_CENTER_EN
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  dir_e dir_q, dir_d;
`endif

  // Duty registers
  logic [CNTR_LEN-1:0] pending_q [NUM_CH];
  logic [CNTR_LEN-1:0] pending_d [NUM_CH];
  logic [CNTR_LEN-1:0] active_q  [NUM_CH];
  logic [CNTR_LEN-1:0] active_d  [NUM_CH];

  // Outputs
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              sync_q, sync_d;

  // Decode
  logic                up_edge;
  logic                dn_edge;
  logic                period_start;
  logic                shadow_load;
  logic [CNTR_LEN:0]   sum_w;

  // Input registration and edge detection
  always_comb begin
    up_d      = i_cycle_up;
    dn_d      = i_cycle_down;
    sel_d     = i_chan_sel;
    up_prev_d = up_q;
    dn_prev_d = dn_q;
    up_edge   = up_q & ~up_prev_q;
    dn_edge   = dn_q & ~dn_prev_q;
  end

  // Counter sequencing
  always_comb begin
`ifdef MULTI_PWM_CENTER_EN
    cnt_d = cnt_q;
    dir_d = dir_q;
    // Each end value is held for one extra cycle while direction flips,
    // so every count is visited twice per period.
    if (dir_q == DIR_UP) begin
      if (cnt_q == TOP_C) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNTR_LEN'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - CNTR_LEN'(1);
      end
    end
    period_start = (cnt_q == '0) && (dir_q == DIR_UP);
    shadow_load  = (cnt_q == '0) && (dir_q == DIR_DOWN);
`else
    cnt_d        = (cnt_q == TOP_C) ? '0 : cnt_q + CNTR_LEN'(1);
    period_start = (cnt_q == '0);
    shadow_load  = (cnt_q == TOP_C);
`endif
  end

  // Pending duty update, shadow load and output compare
  always_comb begin
    sum_w  = '0;
    pwm_d  = '0;
    sync_d = period_start;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pending_d[i] = pending_q[i];
      active_d[i]  = shadow_load ? pending_q[i] : active_q[i];
      pwm_d[i]     = (cnt_q < active_q[i]);
      // A sel value at or above NUM_CH never matches, so the event is dropped.
      if (SEL_W'(i) == sel_q) begin
        if (up_edge && !dn_edge) begin
          sum_w        = {1'b0, pending_q[i]} + STEP_W;
          pending_d[i] = (sum_w > {1'b0, MAX_C}) ? MAX_C : sum_w[CNTR_LEN-1:0];
        end else if (dn_edge && !up_edge) begin
          pending_d[i] = (pending_q[i] >= STEP_N) ? (pending_q[i] - STEP_N) : '0;
        end
      end
    end
  end

  // Pending duty readback; out-of-range selection reads 0
  always_comb begin
    o_duty = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == i_chan_sel) begin
        o_duty = pending_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q      <= 1'b0;
      up_prev_q <= 1'b0;
      dn_q      <= 1'b0;
      dn_prev_q <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
`ifdef MULTI_PWM_CENTER_EN
      dir_q     <= DIR_UP;
`endif
      pwm_q     <= '0;
      sync_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= RESET_D;
        active_q[i]  <= RESET_D;
      end
    end else begin
      up_q      <= up_d;
      up_prev_q <= up_prev_d;
      dn_q      <= dn_d;
      dn_prev_q <= dn_prev_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
`ifdef MULTI_PWM_CENTER_EN
      dir_q     <= dir_d;
`endif
      pwm_q     <= pwm_d;
      sync_q    <= sync_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

  assign PWM_pins = pwm_q;
  assign o_sync   = sync_q;

endmodule
